// File: rtl/reg_mem_responder.sv
// Command responder moving words between a 16x32 memory and an 8x32 register bank; IDLE->EXEC->(RDWAIT)->RESP.
// Response 2 cycles after accept (3 for memory reads); resp_ready low holds RESP and all storage indefinitely.
module reg_mem_responder (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_opcode,
    input  logic [2:0]  cmd_reg_addr,
    input  logic [3:0]  cmd_mem_addr,
    input  logic [31:0] cmd_data,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [1:0]  resp_opcode,
    output logic [31:0] resp_data
);

    typedef enum logic [1:0] {IDLE, EXEC, RDWAIT, RESP} state_t;

    typedef struct packed {
        logic [1:0]  opcode;
        logic [2:0]  reg_addr;
        logic [3:0]  mem_addr;
        logic [31:0] data;
    } cmd_t;

    localparam logic [1:0] OP_DATA_TO_MEM = 2'd0;
    localparam logic [1:0] OP_REG_TO_MEM  = 2'd1;
    localparam logic [1:0] OP_MEM_TO_REG  = 2'd2;

    state_t      state, state_nxt;
    cmd_t        cmd_q;
    logic [31:0] mem [16];
    logic [31:0] regs [8];
    logic [31:0] rd_dat;

    assign cmd_ready  = (state == IDLE);
    assign resp_valid = (state == RESP);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Opcodes 2 and 3 both read memory, so opcode bit 1 selects the read path.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (cmd_valid) state_nxt = EXEC;
            EXEC:    state_nxt = cmd_q.opcode[1] ? RDWAIT : RESP;
            RDWAIT:  state_nxt = RESP;
            RESP:    if (resp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cmd_q       <= '0;
            rd_dat      <= '0;
            resp_opcode <= '0;
            resp_data   <= '0;
            for (int i = 0; i < 16; i++) mem[i]  <= '0;
            for (int i = 0; i < 8; i++)  regs[i] <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid) cmd_q <= {cmd_opcode, cmd_reg_addr, cmd_mem_addr, cmd_data};
                end
                EXEC: begin
                    resp_opcode <= cmd_q.opcode;
                    case (cmd_q.opcode)
                        OP_DATA_TO_MEM: begin
                            mem[cmd_q.mem_addr] <= cmd_q.data;
                            resp_data           <= cmd_q.data;
                        end
                        OP_REG_TO_MEM: begin
                            mem[cmd_q.mem_addr] <= regs[cmd_q.reg_addr];
                            resp_data           <= regs[cmd_q.reg_addr];
                        end
                        // Registered read port: data lands in rd_dat for use in RDWAIT.
                        default: rd_dat <= mem[cmd_q.mem_addr];
                    endcase
                end
                RDWAIT: begin
                    resp_data <= rd_dat;
                    if (cmd_q.opcode == OP_MEM_TO_REG) regs[cmd_q.reg_addr] <= rd_dat;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_reg_mem_responder.sv
// Randomised scoreboard bench for reg_mem_responder against an array-based behavioural model.
module tb_reg_mem_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_opcode = '0;
    logic [2:0]  cmd_reg_addr = '0;
    logic [3:0]  cmd_mem_addr = '0;
    logic [31:0] cmd_data = '0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [1:0]  resp_opcode;
    logic [31:0] resp_data;

    reg_mem_responder dut (
        .clk          (clk),
        .rst          (rst),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_opcode   (cmd_opcode),
        .cmd_reg_addr (cmd_reg_addr),
        .cmd_mem_addr (cmd_mem_addr),
        .cmd_data     (cmd_data),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .resp_opcode  (resp_opcode),
        .resp_data    (resp_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] dat;
        int          acc;
        int          lat;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] mem_m [16];
    logic [31:0] reg_m [8];
    int          cyc = 0;
    int          n_cmp = 0;
    int          n_bad = 0;
    int          rdy_mode = 2;   // 0 random, 1 forced low, 2 forced high

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #2;
        case (rdy_mode)
            0:       resp_ready = 1'($urandom_range(0, 1));
            1:       resp_ready = 1'b0;
            default: resp_ready = 1'b1;
        endcase
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: event did not occur as required (cycle %0d)", name, cyc);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) mem_m[i] = '0;
        for (int i = 0; i < 8; i++)  reg_m[i] = '0;
    endtask

    // Apply a command's effect to the model and queue its expected response.
    task automatic push_exp(input logic [1:0] op, input logic [2:0] ra, input logic [3:0] ma,
                            input logic [31:0] d);
        exp_t e;
        e.op  = op;
        e.acc = cyc;
        e.lat = (op >= 2) ? 3 : 2;
        case (op)
            2'd0: begin mem_m[ma] = d;         e.dat = d;         end
            2'd1: begin mem_m[ma] = reg_m[ra]; e.dat = reg_m[ra]; end
            2'd2: begin reg_m[ra] = mem_m[ma]; e.dat = mem_m[ma]; end
            default: e.dat = mem_m[ma];
        endcase
        sb.push_back(e);
    endtask

    // Entered and left at posedge+1; keep_valid leaves cmd_valid asserted after acceptance.
    task automatic issue(input logic [1:0] op, input logic [2:0] ra, input logic [3:0] ma,
                         input logic [31:0] d, input bit keep_valid);
        bit got = 0;
        cmd_valid = 1'b1; cmd_opcode = op; cmd_reg_addr = ra; cmd_mem_addr = ma; cmd_data = d;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clk);
            if (cmd_ready) begin
                push_exp(op, ra, ma, d);
                got = 1;
            end
            @(posedge clk); #1;
        end
        if (!got) fail("accept_timeout");
        if (!keep_valid) cmd_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 300 && sb.size() != 0; i++) @(negedge clk);
        if (sb.size() != 0) fail("drain_timeout");
        @(posedge clk); #1;
    endtask

    // Monitor: latency, stability under back-pressure, and in-order data/opcode checks.
    logic        prev_vld = 1'b0;
    logic        prev_hs = 1'b0;
    logic [1:0]  prev_op = '0;
    logic [31:0] prev_dat = '0;
    logic        new_resp;
    exp_t        got_e;

    always @(negedge clk) begin
        if (rst) begin
            prev_vld = 1'b0;
            prev_hs  = 1'b0;
        end else begin
            new_resp = resp_valid && (!prev_vld || prev_hs);
            if (resp_valid) begin
                chk("cmd_ready_low_in_resp", 32'(cmd_ready), 32'd0);
                if (!new_resp) begin
                    chk("resp_opcode_stable", 32'(resp_opcode), 32'(prev_op));
                    chk("resp_data_stable", resp_data, prev_dat);
                end
                if (sb.size() == 0) begin
                    if (new_resp) fail("unexpected_response");
                end else begin
                    if (new_resp) chk("latency", 32'(cyc - sb[0].acc), 32'(sb[0].lat));
                    if (resp_ready) begin
                        got_e = sb.pop_front();
                        chk("resp_opcode", 32'(resp_opcode), 32'(got_e.op));
                        chk("resp_data", resp_data, got_e.dat);
                    end
                end
            end
            prev_vld = resp_valid;
            prev_hs  = resp_valid && resp_ready;
            prev_op  = resp_opcode;
            prev_dat = resp_data;
        end
    end

    initial begin
        bit got;
        model_reset();

        // Reset state, then first cycle out of reset
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_resp_opcode", 32'(resp_opcode), 32'd0);
        chk("rst_resp_data", resp_data, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("cmd_ready_after_rst", 32'(cmd_ready), 32'd1);
        @(posedge clk); #1;

        // Directed moves: data->mem, mem->reg, reg->mem, read-out
        issue(2'd0, 3'd0, 4'd1, 32'd10, 0);
        issue(2'd2, 3'd4, 4'd1, 32'd0, 0);
        issue(2'd1, 3'd4, 4'd3, 32'd0, 0);
        issue(2'd3, 3'd0, 4'd3, 32'd0, 0);
        drain();

        // Back-pressure: hold RESP ten cycles
        rdy_mode = 1;
        @(posedge clk); #1;
        issue(2'd3, 3'd0, 4'd5, 32'd0, 0);
        got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            got = resp_valid;
        end
        if (!got) fail("bp_resp_valid_timeout");
        for (int i = 0; i < 10; i++) begin
            chk("bp_resp_valid", 32'(resp_valid), 32'd1);
            chk("bp_cmd_ready", 32'(cmd_ready), 32'd0);
            chk("bp_resp_data", resp_data, 32'd0);
            @(negedge clk);
        end
        rdy_mode = 2;
        got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            got = resp_valid && resp_ready;
        end
        if (!got) fail("bp_handshake_timeout");
        @(negedge clk);
        chk("bp_cmd_ready_after_hs", 32'(cmd_ready), 32'd1);
        chk("bp_resp_valid_after_hs", 32'(resp_valid), 32'd0);
        @(posedge clk); #1;

        // Reset during EXEC cancels the write and the response
        issue(2'd0, 3'd0, 4'd7, 32'hDEADBEEF, 0);
        rst = 1'b1;
        void'(sb.pop_back());
        model_reset();
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("cmd_ready_after_midrst", 32'(cmd_ready), 32'd1);
        chk("resp_valid_after_midrst", 32'(resp_valid), 32'd0);
        @(posedge clk); #1;
        issue(2'd3, 3'd0, 4'd7, 32'd0, 0);
        drain();

        // cmd_valid held high with changing data while busy
        rdy_mode = 0;
        @(posedge clk); #1;
        issue(2'd0, 3'd2, 4'd9, 32'h1111_2222, 1);
        got = 0;
        for (int i = 0; i < 200 && !got; i++) begin
            cmd_data = $urandom;
            @(negedge clk);
            if (cmd_ready) begin
                chk("held_valid_accept_after_hs", 32'(sb.size()), 32'd0);
                push_exp(2'd0, 3'd2, 4'd9, cmd_data);
                got = 1;
            end
            @(posedge clk); #1;
        end
        if (!got) fail("held_valid_second_accept");
        cmd_valid = 1'b0;
        issue(2'd3, 3'd0, 4'd9, 32'd0, 0);
        drain();

        // Randomised traffic with random back-pressure
        for (int n = 0; n < 400; n++) begin
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            issue(2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)),
                  $urandom, 0);
        end
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
